imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Serial program loader: the write-side counterpart of the processor's instruction memory read path. Receives a framed program image over a UART RX line (8N1), assembles big-endian 32-bit words, and drives a write port into instruction memory. Holds the processor in reset via cpu_hold while a load is armed or in progress.

Parameters:
CLKS_PER_BIT, 1085, clock cycles per UART bit (125 MHz / 115200); must be >= 4.
MAX_WORDS, 64, instruction memory depth in words; a larger count byte is rejected.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_serial  input  1  UART RX line, asynchronous, idles high
load_enable  input  1  board switch; high arms and sustains a load
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  32  byte address of write, word index * 4
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  high = processor held in reset
load_done  output  1  one-cycle pulse on successful load
load_error  output  1  sticky error flag; cleared by reset or next count byte
words_loaded  output  8  N from last successful load

Behaviour:
- Reset: all outputs 0; frame FSM IDLE; UART RX idle; internal XOR and word index 0.
- rx_serial passes a 2-flop synchronizer before use.
- UART RX FSM: RX_IDLE -> RX_START on synchronized falling edge. Wait CLKS_PER_BIT/2 (integer divide) and resample. If high, glitch: return to RX_IDLE, no byte, no error. Else RX_DATA: 8 bits LSB first, each sampled CLKS_PER_BIT cycles apart. Then RX_STOP: sample once. High gives a one-cycle rx_valid with the byte. Low is a framing error: no byte, frame FSM aborts with load_error=1. Return to RX_IDLE after stop sample.
- Frame FSM states: IDLE, COUNT, DATA, CHECK.
- IDLE: bytes ignored. load_enable=1 -> COUNT.
- COUNT: first byte = N. Clear load_error, index, and byte counter. Seed XOR with N. N==0 or N>MAX_WORDS sets load_error=1 and goes to IDLE.
- DATA: bytes shift into the word register, first byte -> [31:24]. Each byte XORs into the checksum. On the 4th byte's rx_valid, the next cycle has imem_we=1, imem_addr=index*4, imem_wdata=word, and index increments. After word N -> CHECK.
- CHECK: next byte compared to the XOR. Match gives load_done=1 the following cycle and words_loaded=N. Mismatch sets load_error=1; written words are not rolled back. Either way -> IDLE.
- Re-arm: the FSM must see load_enable=0 in IDLE before re-entering COUNT. Holding the switch high does not start a second load.
- load_enable=0 in COUNT/DATA/CHECK: abort to IDLE and set load_error=1. Any partial word is discarded and imem_we is not asserted.
- cpu_hold = load_enable OR (state != IDLE). It deasserts the cycle after load_done when load_enable is already low; otherwise when the switch drops.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-byte or mid-frame: immediate return to IDLE/RX_IDLE, outputs 0, no write.
- Byte timing: a full byte completes 9.5 bit periods after the start edge. Back-to-back bytes with no idle gap must be received.

Test Plan:
- CLKS_PER_BIT=8. load_enable=1, then send 02 20 08 00 05 AC 08 00 00 8B -> imem_we at addr 0x0 data 0x20080005 and addr 0x4 data 0xAC080000. load_done pulses once, words_loaded=2, load_error=0. Switch low -> cpu_hold=0.
- Same frame, checksum 0x8A -> both writes occur, load_error=1, no load_done.
- Count byte 00, then separately 41 (N=65) -> load_error=1, no imem_we, FSM IDLE.
- rx_serial low for 2 cycles only -> no rx_valid, no error. A following valid frame loads correctly.
- Drop load_enable after 6 data bytes -> one write (word 0), load_error=1, cpu_hold=0 next cycle. Assert reset mid-byte on a new load -> all outputs 0.
- Stop bit driven low on byte 3 -> load_error=1, no write for the partial word.

Source files
------------

// File: rtl/imem_loader_if.sv
// Bundle between the serial program loader and the board/instruction-memory side.
// The loader drives the write port and status; the peer drives the UART line and the switch.
interface imem_loader_if;
  logic        rx_serial;
  logic        load_enable;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [7:0]  words_loaded;

  modport master (
    input  rx_serial, load_enable,
    output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error, words_loaded
  );

  modport slave (
    output rx_serial, load_enable,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: UART 8N1 receiver feeding a frame FSM that writes big-endian
// words into instruction memory and holds the CPU in reset while loading.
//
// rx state | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, then confirm the start bit
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling the stop bit
//
// frame state | meaning
// F_IDLE      | bytes ignored, waiting for an armed load_enable
// F_COUNT     | expecting the word-count byte
// F_DATA      | assembling and writing words
// F_CHECK     | expecting the XOR checksum byte
module imem_loader #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int MAX_WORDS    = 64
) (
  input logic           clock,
  input logic           reset,
  imem_loader_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   MAX_W     = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_COUNT, F_DATA, F_CHECK} f_state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_byte;

  f_state_e    f_state_q, f_state_d;
  logic        armed_q, armed_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  xor_q, xor_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  wl_q, wl_d;
  logic        hold_q, hold_d;

  // Line idles high, so the synchronizer resets high to avoid a false start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx_serial;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) rx_state_d = RX_IDLE;
        else                rx_cnt_d   = rx_cnt_q - 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_sync_q;
    rx_ferr  = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && !rx_sync_q;
    rx_byte  = rx_shift_q;
  end

  // armed_q resets high so a switch already on at power-up starts a load.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_state_q <= F_IDLE;
      armed_q   <= 1'b1;
      n_q       <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      xor_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wl_q      <= '0;
      hold_q    <= 1'b0;
    end else begin
      f_state_q <= f_state_d;
      armed_q   <= armed_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      xor_q     <= xor_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wl_q      <= wl_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    f_state_d = f_state_q;
    armed_d   = armed_q;
    n_d       = n_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    xor_d     = xor_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wl_d      = wl_q;
    if (f_state_q == F_IDLE) begin
      if (!bus.load_enable) begin
        armed_d = 1'b1;
      end else if (armed_q) begin
        f_state_d = F_COUNT;
        armed_d   = 1'b0;
      end
    end else if (!bus.load_enable || rx_ferr) begin
      f_state_d = F_IDLE;
      err_d     = 1'b1;
    end else if (rx_valid) begin
      case (f_state_q)
        F_COUNT: begin
          err_d  = 1'b0;
          idx_d  = '0;
          bcnt_d = '0;
          xor_d  = rx_byte;
          n_d    = rx_byte;
          if (rx_byte == 8'd0 || {24'd0, rx_byte} > MAX_W) begin
            err_d     = 1'b1;
            f_state_d = F_IDLE;
          end else begin
            f_state_d = F_DATA;
          end
        end
        F_DATA: begin
          word_d = {word_q[15:0], rx_byte};
          xor_d  = xor_q ^ rx_byte;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {22'd0, idx_q, 2'b00};
            wdata_d = {word_q, rx_byte};
            idx_d   = idx_q + 8'd1;
            if (idx_q + 8'd1 == n_q) f_state_d = F_CHECK;
          end
        end
        F_CHECK: begin
          if (rx_byte == xor_q) begin
            done_d = 1'b1;
            wl_d   = n_q;
          end else begin
            err_d = 1'b1;
          end
          f_state_d = F_IDLE;
        end
        default: f_state_d = F_IDLE;
      endcase
    end
    // done_d keeps the hold up through the load_done cycle.
    hold_d = bus.load_enable || (f_state_d != F_IDLE) || done_d;
  end

  always_comb begin
    bus.imem_we      = we_q;
    bus.imem_addr    = addr_q;
    bus.imem_wdata   = wdata_q;
    bus.cpu_hold     = hold_q;
    bus.load_done    = done_q;
    bus.load_error   = err_q;
    bus.words_loaded = wl_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete frames plus hand-written
// sequences for re-arm, glitch, abort, framing error and mid-byte reset.
module tb_imem_loader;
  localparam int CPB = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  imem_loader_if bus();

  imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [95:0] bytes;
    int          len;
    int          exp_we;
    logic [31:0] a0, d0, a1, d1;
    int          exp_done;
    logic        exp_err;
    logic [7:0]  exp_wl;
  } vec_t;

  vec_t vecs[5];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int done_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.imem_we) begin
        wr_addr.push_back(bus.imem_addr);
        wr_data.push_back(bus.imem_wdata);
      end
      if (bus.load_done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx_serial = b[i];
      tick(CPB);
    end
    bus.rx_serial = stop_bit;
    tick(CPB);
    bus.rx_serial = 1'b1;
  endtask

  task automatic send_frame(input logic [95:0] bytes, input int len);
    for (int i = 0; i < len; i++) send_byte(bytes[95-8*i -: 8], 1'b1);
  endtask

  task automatic arm();
    bus.load_enable = 1'b0;
    tick(3);
    bus.load_enable = 1'b1;
    tick(2);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int wbase, dbase;
    arm();
    check($sformatf("v%0d cpu_hold armed", k), 32'(bus.cpu_hold), 32'd1);
    wbase = wr_addr.size();
    dbase = done_cnt;
    send_frame(v.bytes, v.len);
    tick(3 * CPB);
    check($sformatf("v%0d write count", k), 32'(wr_addr.size() - wbase), 32'(v.exp_we));
    if (v.exp_we >= 1 && wr_addr.size() > wbase) begin
      check($sformatf("v%0d addr0", k), wr_addr[wbase], v.a0);
      check($sformatf("v%0d data0", k), wr_data[wbase], v.d0);
    end
    if (v.exp_we >= 2 && wr_addr.size() > wbase + 1) begin
      check($sformatf("v%0d addr1", k), wr_addr[wbase+1], v.a1);
      check($sformatf("v%0d data1", k), wr_data[wbase+1], v.d1);
    end
    check($sformatf("v%0d done pulses", k), 32'(done_cnt - dbase), 32'(v.exp_done));
    check($sformatf("v%0d load_error", k), 32'(bus.load_error), 32'(v.exp_err));
    check($sformatf("v%0d words_loaded", k), 32'(bus.words_loaded), 32'(v.exp_wl));
    bus.load_enable = 1'b0;
    tick(1);
    check($sformatf("v%0d cpu_hold released", k), 32'(bus.cpu_hold), 32'd0);
  endtask

  localparam logic [95:0] GOOD = 96'h0220080005AC0800008B0000;

  initial begin
    int wbase, dbase;
    vecs[0] = '{GOOD,                        10, 2, 32'h0, 32'h20080005, 32'h4, 32'hAC080000, 1, 1'b0, 8'd2};
    vecs[1] = '{96'h0220080005AC0800008A0000, 10, 2, 32'h0, 32'h20080005, 32'h4, 32'hAC080000, 0, 1'b1, 8'd2};
    vecs[2] = '{96'h000000000000000000000000,  1, 0, 32'h0, 32'h0,        32'h0, 32'h0,        0, 1'b1, 8'd2};
    vecs[3] = '{96'h410000000000000000000000,  1, 0, 32'h0, 32'h0,        32'h0, 32'h0,        0, 1'b1, 8'd2};
    vecs[4] = '{96'h01DEADBEEF23000000000000,  6, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0,        1, 1'b0, 8'd1};

    reset = 1'b1;
    bus.rx_serial = 1'b1;
    bus.load_enable = 1'b0;
    tick(4);
    check("reset imem_we", 32'(bus.imem_we), 32'd0);
    check("reset imem_addr", bus.imem_addr, 32'd0);
    check("reset imem_wdata", bus.imem_wdata, 32'd0);
    check("reset cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("reset load_done", 32'(bus.load_done), 32'd0);
    check("reset load_error", 32'(bus.load_error), 32'd0);
    check("reset words_loaded", 32'(bus.words_loaded), 32'd0);
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Switch held high: second frame must be ignored.
    arm();
    wbase = wr_addr.size();
    dbase = done_cnt;
    send_frame(GOOD, 10);
    tick(3 * CPB);
    send_frame(GOOD, 10);
    tick(3 * CPB);
    check("rearm writes", 32'(wr_addr.size() - wbase), 32'd2);
    check("rearm done pulses", 32'(done_cnt - dbase), 32'd1);
    check("rearm cpu_hold", 32'(bus.cpu_hold), 32'd1);

    // Two-cycle glitch while waiting for the count byte.
    arm();
    wbase = wr_addr.size();
    dbase = done_cnt;
    bus.rx_serial = 1'b0;
    tick(2);
    bus.rx_serial = 1'b1;
    tick(4 * CPB);
    check("glitch load_error", 32'(bus.load_error), 32'd0);
    check("glitch writes", 32'(wr_addr.size() - wbase), 32'd0);
    send_frame(GOOD, 10);
    tick(3 * CPB);
    check("post-glitch writes", 32'(wr_addr.size() - wbase), 32'd2);
    check("post-glitch done", 32'(done_cnt - dbase), 32'd1);
    check("post-glitch load_error", 32'(bus.load_error), 32'd0);

    // N = MAX_WORDS is accepted; then abort by switch.
    arm();
    send_byte(8'h40, 1'b1);
    tick(2 * CPB);
    check("N=64 load_error", 32'(bus.load_error), 32'd0);
    bus.load_enable = 1'b0;
    tick(1);
    check("N=64 abort error", 32'(bus.load_error), 32'd1);
    check("N=64 abort cpu_hold", 32'(bus.cpu_hold), 32'd0);

    // Drop the switch after six data bytes: only word 0 written.
    arm();
    wbase = wr_addr.size();
    send_frame(GOOD, 7);
    tick(2 * CPB);
    bus.load_enable = 1'b0;
    tick(1);
    check("abort cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("abort load_error", 32'(bus.load_error), 32'd1);
    tick(3);
    check("abort writes", 32'(wr_addr.size() - wbase), 32'd1);
    if (wr_addr.size() > wbase) begin
      check("abort addr", wr_addr[wbase], 32'h0);
      check("abort data", wr_data[wbase], 32'h20080005);
    end

    // Framing error on the third byte.
    arm();
    wbase = wr_addr.size();
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h08, 1'b0);
    tick(2 * CPB);
    check("ferr load_error", 32'(bus.load_error), 32'd1);
    check("ferr writes", 32'(wr_addr.size() - wbase), 32'd0);
    bus.load_enable = 1'b0;
    tick(2);

    // Reset in the middle of a byte.
    arm();
    wbase = wr_addr.size();
    send_byte(8'h02, 1'b1);
    check("pre-reset load_error", 32'(bus.load_error), 32'd0);
    bus.rx_serial = 1'b0;
    tick(CPB);
    bus.rx_serial = 1'b1;
    tick(CPB / 2);
    reset = 1'b1;
    tick(2);
    check("midreset imem_we", 32'(bus.imem_we), 32'd0);
    check("midreset imem_addr", bus.imem_addr, 32'd0);
    check("midreset imem_wdata", bus.imem_wdata, 32'd0);
    check("midreset cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check("midreset load_done", 32'(bus.load_done), 32'd0);
    check("midreset load_error", 32'(bus.load_error), 32'd0);
    check("midreset words_loaded", 32'(bus.words_loaded), 32'd0);
    bus.load_enable = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(4 * CPB);
    check("post-reset writes", 32'(wr_addr.size() - wbase), 32'd0);
    check("post-reset cpu_hold", 32'(bus.cpu_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
